sram_port_arbiter: RTL and testbench

Shares one synchronous single-port SRAM between the CPU's instruction-fetch and data-access requesters. It sits between the IF/EXE-stage SRAM-like request interfaces and a unified memory macro. Each cycle it grants at most one access, tracks the owner of every in-flight access through a fixed-latency tag pipeline, and returns each response only to the requester that issued it. Fixed data-over-instruction priority with a starvation guard is the default; round-robin is a build option.

---
 rtl/sram_port_arbiter_pkg.sv | 21 ++
 rtl/sram_port_arbiter_if.sv | 50 +++++
 rtl/sram_arb_tag_pipe.sv | 31 +++
 rtl/sram_port_arbiter.sv | 114 +++++++++++
 tb/tb_sram_port_arbiter.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_port_arbiter_pkg.sv
// Shared definitions for the SRAM port arbiter: owner encoding, the in-flight tag
// record and the legal read-latency range.
package sram_port_arbiter_pkg;

  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  localparam int TAG_W       = 1 + 1;
  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 4;

  typedef struct packed {
    logic valid;
    logic owner;
  } tag_t;

  function automatic bit mem_lat_ok(input int lat);
    return (lat >= MEM_LAT_MIN) && (lat <= MEM_LAT_MAX);
  endfunction

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Bundle of the two SRAM-like requester ports plus the unified memory port.
// Requesters hold req with stable addr/wr/wstrb/wdata; a transfer is taken in the
// cycle req & addr_ok are both high, and its data_ok pulses once, in grant order.
interface sram_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                inst_req;
  logic                inst_wr;
  logic [DATA_W/8-1:0] inst_wstrb;
  logic [ADDR_W-1:0]   inst_addr;
  logic [DATA_W-1:0]   inst_wdata;
  logic                inst_addr_ok;
  logic                inst_data_ok;
  logic [DATA_W-1:0]   inst_rdata;

  logic                data_req;
  logic                data_wr;
  logic [DATA_W/8-1:0] data_wstrb;
  logic [ADDR_W-1:0]   data_addr;
  logic [DATA_W-1:0]   data_wdata;
  logic                data_addr_ok;
  logic                data_data_ok;
  logic [DATA_W-1:0]   data_rdata;

  logic                mem_en;
  logic [DATA_W/8-1:0] mem_wen;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   mem_rdata;

  modport master (
    output inst_req, inst_wr, inst_wstrb, inst_addr, inst_wdata,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    output data_req, data_wr, data_wstrb, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  mem_en, mem_wen, mem_addr, mem_wdata,
    output mem_rdata
  );

  modport slave (
    input  inst_req, inst_wr, inst_wstrb, inst_addr, inst_wdata,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_req, data_wr, data_wstrb, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output mem_en, mem_wen, mem_addr, mem_wdata,
    input  mem_rdata
  );

endinterface

// File: rtl/sram_arb_tag_pipe.sv
// Fixed-latency {valid, owner} shift register that follows each SRAM access until
// its read data returns; reset drops every in-flight tag at once.
module sram_arb_tag_pipe
  import sram_port_arbiter_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic clk,
  input  logic resetn,
  input  tag_t tag_in,
  output tag_t tag_out
);

  if ($bits(tag_t) != TAG_W) begin : g_bad_tag
    $error("tag_t width does not match TAG_W");
  end

  tag_t stage [MEM_LAT];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < MEM_LAT; i++) stage[i] <= '0;
    end else begin
      stage[0] <= tag_in;
      for (int i = 1; i < MEM_LAT; i++) stage[i] <= stage[i-1];
    end
  end

  assign tag_out = stage[MEM_LAT-1];

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-port SRAM between instruction fetch and data access.
// Default: data priority with starvation guard; define SRAM_ARB_RR_EN for round-robin.
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 8
) (
  input logic               clk,
  input logic               resetn,
  sram_port_arbiter_if.slave bus
);

  localparam int STRB_W = DATA_W / 8;

  if (!mem_lat_ok(MEM_LAT)) begin : g_bad_lat
    $error("MEM_LAT must be in 1..4");
  end

  logic              inst_win;
  logic              inst_gnt;
  logic              data_gnt;
  logic              hs;
  logic              win_owner;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [STRB_W-1:0] sel_wen;
  logic              inst_resp;
  logic              data_resp;
  tag_t              tag_in;
  tag_t              tag_out;

`ifdef SRAM_ARB_RR_EN
  logic last_grant;

  // On a tie the requester that did not win the previous handshake goes first.
  assign inst_win = bus.inst_req & (~bus.data_req | (last_grant == OWN_DATA));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)  last_grant <= OWN_INST;
    else if (hs)  last_grant <= win_owner;
  end
`else
  if (STARVE_MAX < 1 || STARVE_MAX > 255) begin : g_bad_starve
    $error("STARVE_MAX must be in 1..255");
  end

  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

  logic [7:0] starve_cnt;
  logic       force_inst;

  assign force_inst = (starve_cnt == STARVE_LIM);
  assign inst_win   = bus.inst_req & (~bus.data_req | force_inst);

  // Counts consecutive denied inst cycles; any gap in inst_req restarts the count.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                        starve_cnt <= '0;
    else if (!bus.inst_req || inst_gnt) starve_cnt <= '0;
    else if (!force_inst)               starve_cnt <= starve_cnt + 8'd1;
  end
`endif

  // Gating with resetn keeps every grant and memory strobe quiet while in reset.
  assign inst_gnt  = resetn & inst_win;
  assign data_gnt  = resetn & bus.data_req & ~inst_win;
  assign hs        = inst_gnt | data_gnt;
  assign win_owner = data_gnt ? OWN_DATA : OWN_INST;

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wen   = '0;
    if (inst_gnt) begin
      sel_addr  = bus.inst_addr;
      sel_wdata = bus.inst_wdata;
      sel_wen   = bus.inst_wr ? bus.inst_wstrb : '0;
    end else if (data_gnt) begin
      sel_addr  = bus.data_addr;
      sel_wdata = bus.data_wdata;
      sel_wen   = bus.data_wr ? bus.data_wstrb : '0;
    end
  end

  assign bus.inst_addr_ok = inst_gnt;
  assign bus.data_addr_ok = data_gnt;
  assign bus.mem_en       = hs;
  assign bus.mem_wen      = sel_wen;
  assign bus.mem_addr     = sel_addr;
  assign bus.mem_wdata    = sel_wdata;

  assign tag_in = '{valid: hs, owner: win_owner};

  sram_arb_tag_pipe #(
    .MEM_LAT (MEM_LAT)
  ) u_tag_pipe (
    .clk     (clk),
    .resetn  (resetn),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  // Reads and writes are acknowledged identically; only the owner sees mem_rdata.
  assign inst_resp = tag_out.valid & (tag_out.owner == OWN_INST);
  assign data_resp = tag_out.valid & (tag_out.owner == OWN_DATA);

  assign bus.inst_data_ok = inst_resp;
  assign bus.data_data_ok = data_resp;
  assign bus.inst_rdata   = inst_resp ? bus.mem_rdata : '0;
  assign bus.data_rdata   = data_resp ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: a vector table on a MEM_LAT=1 instance and
// hand-written arbitration, latency and reset sequences on MEM_LAT=1/3 instances.
module tb_sram_port_arbiter;

  logic clk = 1'b0;
  logic resetn;
  int   total_cnt = 0;
  int   pass_cnt  = 0;

  always #5 clk = ~clk;

  sram_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_a ();
  sram_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_b ();

  sram_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(8)) dut_a (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus_a)
  );

  sram_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(8)) dut_b (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus_b)
  );

  typedef struct {
    logic        ireq, iwr;
    logic [3:0]  iwstrb;
    logic [31:0] iaddr, iwdata;
    logic        dreq, dwr;
    logic [3:0]  dwstrb;
    logic [31:0] daddr, dwdata, mrdata;
    logic        iaok, daok, men;
    logic [3:0]  mwen;
    logic [31:0] maddr, mwdata;
    logic        idok, ddok;
    logic [31:0] irdata, drdata;
  } vec_t;

  vec_t vecs [11];

  function automatic logic [191:0] pk(logic iaok, logic daok, logic men, logic [3:0] mwen,
                                      logic [31:0] maddr, logic [31:0] mwdata,
                                      logic idok, logic ddok,
                                      logic [31:0] ird, logic [31:0] drd);
    return {55'd0, iaok, daok, men, mwen, maddr, mwdata, idok, ddok, ird, drd};
  endfunction

  // mask_addr blanks mem_addr/mem_wdata, whose value is free when nothing is granted.
  function automatic logic [191:0] obs_a(logic mask_addr);
    return pk(bus_a.inst_addr_ok, bus_a.data_addr_ok, bus_a.mem_en, bus_a.mem_wen,
              mask_addr ? 32'd0 : bus_a.mem_addr, mask_addr ? 32'd0 : bus_a.mem_wdata,
              bus_a.inst_data_ok, bus_a.data_data_ok, bus_a.inst_rdata, bus_a.data_rdata);
  endfunction

  function automatic logic [191:0] obs_b(logic mask_addr);
    return pk(bus_b.inst_addr_ok, bus_b.data_addr_ok, bus_b.mem_en, bus_b.mem_wen,
              mask_addr ? 32'd0 : bus_b.mem_addr, mask_addr ? 32'd0 : bus_b.mem_wdata,
              bus_b.inst_data_ok, bus_b.data_data_ok, bus_b.inst_rdata, bus_b.data_rdata);
  endfunction

  function automatic vec_t mk(logic ireq, logic iwr, logic [3:0] iwstrb, logic [31:0] iaddr,
                              logic [31:0] iwdata, logic dreq, logic dwr, logic [3:0] dwstrb,
                              logic [31:0] daddr, logic [31:0] dwdata, logic [31:0] mrdata,
                              logic iaok, logic daok, logic men, logic [3:0] mwen,
                              logic [31:0] maddr, logic [31:0] mwdata, logic idok, logic ddok,
                              logic [31:0] irdata, logic [31:0] drdata);
    vec_t v;
    v.ireq = ireq;   v.iwr = iwr;   v.iwstrb = iwstrb; v.iaddr = iaddr; v.iwdata = iwdata;
    v.dreq = dreq;   v.dwr = dwr;   v.dwstrb = dwstrb; v.daddr = daddr; v.dwdata = dwdata;
    v.mrdata = mrdata;
    v.iaok = iaok;   v.daok = daok; v.men = men; v.mwen = mwen;
    v.maddr = maddr; v.mwdata = mwdata;
    v.idok = idok;   v.ddok = ddok; v.irdata = irdata; v.drdata = drdata;
    return v;
  endfunction

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic idle_a();
    bus_a.inst_req = 0; bus_a.inst_wr = 0; bus_a.inst_wstrb = 0;
    bus_a.inst_addr = 0; bus_a.inst_wdata = 0;
    bus_a.data_req = 0; bus_a.data_wr = 0; bus_a.data_wstrb = 0;
    bus_a.data_addr = 0; bus_a.data_wdata = 0; bus_a.mem_rdata = 0;
  endtask

  task automatic idle_b();
    bus_b.inst_req = 0; bus_b.inst_wr = 0; bus_b.inst_wstrb = 0;
    bus_b.inst_addr = 0; bus_b.inst_wdata = 0;
    bus_b.data_req = 0; bus_b.data_wr = 0; bus_b.data_wstrb = 0;
    bus_b.data_addr = 0; bus_b.data_wdata = 0; bus_b.mem_rdata = 0;
  endtask

  task automatic drive_a(input vec_t v);
    bus_a.inst_req = v.ireq; bus_a.inst_wr = v.iwr; bus_a.inst_wstrb = v.iwstrb;
    bus_a.inst_addr = v.iaddr; bus_a.inst_wdata = v.iwdata;
    bus_a.data_req = v.dreq; bus_a.data_wr = v.dwr; bus_a.data_wstrb = v.dwstrb;
    bus_a.data_addr = v.daddr; bus_a.data_wdata = v.dwdata; bus_a.mem_rdata = v.mrdata;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    resetn = 0;
    idle_a();
    idle_b();
    @(negedge clk);
    @(negedge clk);
    resetn = 1;
  endtask

  initial begin
    logic exp_inst, prev_inst;
    logic iaok, daok, idok, ddok;
    logic [31:0] maddr, ird, drd;

    // ireq iwr iwstrb iaddr iwdata | dreq dwr dwstrb daddr dwdata | mrdata ||
    // iaok daok men mwen maddr mwdata | idok ddok irdata drdata
    vecs[0]  = mk(0,0,4'h0,32'h0,32'h0,            0,0,4'h0,32'h0,32'h0,            32'h0,
                  0,0,0,4'h0,32'h0,32'h0,           0,0,32'h0,32'h0);
    vecs[1]  = mk(1,0,4'hF,32'h0000_1000,32'h0,    0,0,4'h0,32'h0,32'h0,            32'h0,
                  1,0,1,4'h0,32'h0000_1000,32'h0,   0,0,32'h0,32'h0);
    vecs[2]  = mk(0,0,4'h0,32'h0,32'h0,            0,0,4'h0,32'h0,32'h0,            32'hDEAD_BEEF,
                  0,0,0,4'h0,32'h0,32'h0,           1,0,32'hDEAD_BEEF,32'h0);
    vecs[3]  = mk(0,0,4'h0,32'h0,32'h0,            1,1,4'b0011,32'h80,32'h1234_5678, 32'h0,
                  0,1,1,4'b0011,32'h80,32'h1234_5678, 0,0,32'h0,32'h0);
    vecs[4]  = mk(0,0,4'h0,32'h0,32'h0,            0,0,4'h0,32'h0,32'h0,            32'hAAAA_5555,
                  0,0,0,4'h0,32'h0,32'h0,           0,1,32'h0,32'hAAAA_5555);
    vecs[5]  = mk(1,1,4'hF,32'h44,32'hCAFE_0001,   0,0,4'h0,32'h0,32'h0,            32'h0,
                  1,0,1,4'hF,32'h44,32'hCAFE_0001,  0,0,32'h0,32'h0);
    vecs[6]  = mk(1,0,4'h0,32'h100,32'h6,          1,0,4'h0,32'h200,32'h5,          32'h11,
                  0,1,1,4'h0,32'h200,32'h5,         1,0,32'h11,32'h0);
    vecs[7]  = mk(0,0,4'h0,32'h0,32'h0,            1,0,4'hF,32'h300,32'h0,          32'h22,
                  0,1,1,4'h0,32'h300,32'h0,         0,1,32'h0,32'h22);
    vecs[8]  = mk(0,0,4'h0,32'h0,32'h0,            1,1,4'b1100,32'h500,32'h9999_0000, 32'h33,
                  0,1,1,4'b1100,32'h500,32'h9999_0000, 0,1,32'h0,32'h33);
    vecs[9]  = mk(0,0,4'h0,32'h0,32'h0,            0,0,4'h0,32'h0,32'h0,            32'h44,
                  0,0,0,4'h0,32'h0,32'h0,           0,1,32'h0,32'h44);
    vecs[10] = mk(0,0,4'h0,32'h0,32'h0,            0,0,4'h0,32'h0,32'h0,            32'h0,
                  0,0,0,4'h0,32'h0,32'h0,           0,0,32'h0,32'h0);

    // Reset state: requests held high must not leak through.
    resetn = 0;
    idle_a();
    idle_b();
    bus_a.inst_req = 1; bus_a.inst_addr = 32'h1234; bus_a.inst_wdata = 32'h5555;
    bus_a.data_req = 1; bus_a.data_wr = 1; bus_a.data_wstrb = 4'hF; bus_a.data_addr = 32'h88;
    bus_a.mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    #1;
    check("reset_outputs", obs_a(1'b0), pk(0,0,0,4'h0,32'h0,32'h0,0,0,32'h0,32'h0));
    @(negedge clk);
    idle_a();
    resetn = 1;

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      drive_a(vecs[i]);
      #1;
      check($sformatf("vec%0d", i), obs_a(!vecs[i].men),
            pk(vecs[i].iaok, vecs[i].daok, vecs[i].men, vecs[i].mwen, vecs[i].maddr,
               vecs[i].mwdata, vecs[i].idok, vecs[i].ddok, vecs[i].irdata, vecs[i].drdata));
    end

    // Both requesters ask every cycle from a fresh reset.
    pulse_reset();
    prev_inst = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus_a.inst_req = 1; bus_a.inst_addr = 32'h1000 + i;
      bus_a.data_req = 1; bus_a.data_addr = 32'h2000 + i;
      bus_a.mem_rdata = (i == 0) ? 32'h0 : 32'h100 + i;
`ifdef SRAM_ARB_RR_EN
      exp_inst = (i % 2 == 1);
`else
      exp_inst = (i % 9 == 8);
`endif
      iaok  = exp_inst;
      daok  = !exp_inst;
      maddr = exp_inst ? 32'h1000 + i : 32'h2000 + i;
      idok  = (i > 0) && prev_inst;
      ddok  = (i > 0) && !prev_inst;
      ird   = idok ? 32'h100 + i : 32'h0;
      drd   = ddok ? 32'h100 + i : 32'h0;
      #1;
      check($sformatf("both_req_cyc%0d", i), obs_a(1'b0),
            pk(iaok, daok, 1'b1, 4'h0, maddr, 32'h0, idok, ddok, ird, drd));
      prev_inst = exp_inst;
    end
    @(negedge clk);
    idle_a();

    // MEM_LAT=3: inst, data, inst back to back; responses three cycles later.
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      idle_b();
      iaok = (c == 0) || (c == 2);
      daok = (c == 1);
      idok = (c == 3) || (c == 5);
      ddok = (c == 4);
      maddr = 32'h0;
      if (c == 0) begin bus_b.inst_req = 1; bus_b.inst_addr = 32'h10; maddr = 32'h10; end
      if (c == 1) begin bus_b.data_req = 1; bus_b.data_addr = 32'h20; maddr = 32'h20; end
      if (c == 2) begin bus_b.inst_req = 1; bus_b.inst_addr = 32'h30; maddr = 32'h30; end
      bus_b.mem_rdata = (idok || ddok) ? 32'h200 + c : 32'h0;
      ird = idok ? 32'h200 + c : 32'h0;
      drd = ddok ? 32'h200 + c : 32'h0;
      #1;
      check($sformatf("lat3_cyc%0d", c), obs_b(!(iaok || daok)),
            pk(iaok, daok, iaok || daok, 4'h0, maddr, 32'h0, idok, ddok, ird, drd));
    end

    // Reset one cycle after two handshakes drops both in-flight accesses.
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      idle_b();
      if (c == 0) begin bus_b.inst_req = 1; bus_b.inst_addr = 32'h40; end
      if (c == 1) begin bus_b.data_req = 1; bus_b.data_addr = 32'h50; end
      if (c == 2 || c == 3) begin
        resetn = 0;
        bus_b.inst_req = 1; bus_b.inst_addr = 32'h60;
        bus_b.data_req = 1; bus_b.data_addr = 32'h70;
        bus_b.mem_rdata = 32'hBAD0_BAD0;
      end
      if (c == 4) resetn = 1;
      if (c == 9) begin bus_b.inst_req = 1; bus_b.inst_addr = 32'h80; end
      if (c == 12) bus_b.mem_rdata = 32'h600D;
      #1;
      if (c == 2 || c == 3)
        check($sformatf("rst_mid_cyc%0d", c), obs_b(1'b0),
              pk(0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0));
      else if (c >= 4 && c <= 8)
        check($sformatf("rst_after_cyc%0d", c),
              {188'd0, bus_b.inst_addr_ok, bus_b.data_addr_ok,
               bus_b.inst_data_ok, bus_b.data_data_ok}, 192'd0);
      else if (c == 9)
        check("rst_new_hs", obs_b(1'b0),
              pk(1, 0, 1, 4'h0, 32'h80, 32'h0, 0, 0, 32'h0, 32'h0));
      else if (c == 12)
        check("rst_new_resp", obs_b(1'b1),
              pk(0, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 32'h600D, 32'h0));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
